// File: rtl/keep_one_in_n_unzip_pkg.sv
// Shared constants, holding-register type and nibble expansion for keep_one_in_n_unzip.
// Define KEEP_ONE_IN_N_UNZIP_ROUND_EN to add the half-LSB bias to each expanded component.
package keep_one_in_n_unzip_pkg;

  localparam int unsigned SYMS_PER_WORD = 4;
  localparam int unsigned SYM_W         = 8;
  localparam int unsigned NIB_W         = 4;
  localparam int unsigned EXP_LSB       = 11;
  localparam logic [15:0] ROUND_BIAS    = 16'h0400;

`ifdef KEEP_ONE_IN_N_UNZIP_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  typedef struct packed {
    logic [SYMS_PER_WORD*SYM_W-1:0] data;
    logic                           last;
  } hold_t;

  // The packer dropped the redundant sign bit; duplicating s restores it.
  function automatic logic [15:0] nib_expand(input logic [NIB_W-1:0] nib);
    logic [15:0] v;
    v = {nib[NIB_W-1], nib, {EXP_LSB{1'b0}}};
    v = v | (ROUND_EN ? ROUND_BIAS : 16'h0000);
    return v;
  endfunction

endpackage

// File: rtl/keep_one_in_n_unzip.sv
// Unpacks each 32-bit word of four I/Q nibble symbols into four 32-bit expanded beats.
// Optional rounding bias is enabled by the KEEP_ONE_IN_N_UNZIP_ROUND_EN macro (see package).
module keep_one_in_n_unzip
  import keep_one_in_n_unzip_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
);

  generate
    if (WIDTH != 32) begin : g_width_check
      $error("keep_one_in_n_unzip: only WIDTH=32 is supported");
    end
  endgenerate

  hold_t      hold;
  logic       full;
  logic [1:0] idx;

  logic             last_beat;
  logic             in_hs;
  logic             out_hs;
  logic [SYM_W-1:0] sym;

  always_comb begin
    last_beat = (idx == 2'd3);
    i_tready  = ~full | (o_tready & last_beat);
    in_hs     = i_tvalid & i_tready;
    out_hs    = full & o_tready;
  end

  always_comb begin
    sym = '0;
    for (int unsigned k = 0; k < SYMS_PER_WORD; k++) begin
      if (idx == k[1:0]) begin
        sym = hold.data[(SYMS_PER_WORD-1-k)*SYM_W +: SYM_W];
      end
    end
  end

  // Gated by full so the bias never appears on an idle or reset output.
  always_comb begin
    o_tvalid = full;
    o_tlast  = full & last_beat & hold.last;
    o_tdata  = full ? {nib_expand(sym[SYM_W-1:NIB_W]), nib_expand(sym[NIB_W-1:0])} : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold <= '0;
      full <= 1'b0;
      idx  <= '0;
    end else if (in_hs) begin
      hold <= '{data: i_tdata, last: i_tlast};
      full <= 1'b1;
      idx  <= '0;
    end else if (out_hs) begin
      if (last_beat) begin
        full <= 1'b0;
        idx  <= '0;
      end else begin
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_keep_one_in_n_unzip.sv
// Self-checking bench for keep_one_in_n_unzip: directed vectors, back-to-back, random stalls, mid-word reset.
module tb_keep_one_in_n_unzip;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       q[$];
  logic [31:0] obs_d;
  logic        obs_l;
  logic        obs_v;
  logic        obs_r;
  int          words_acc;
  int          beats_rx;

  keep_one_in_n_unzip #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  // Expanded component = signed nibble scaled by 2^11, optionally plus half LSB.
  function automatic logic [15:0] ref_comp(input logic [3:0] n);
    int v;
    v = (n >= 4'd8) ? int'(n) - 16 : int'(n);
    v = v * 2048;
`ifdef KEEP_ONE_IN_N_UNZIP_ROUND_EN
    v = v + 1024;
`endif
    return v[15:0];
  endfunction

  task automatic push_word(input logic [31:0] d, input logic l);
    beat_t b;
    logic [7:0] s;
    for (int k = 0; k < 4; k++) begin
      s   = 8'((d >> (24 - 8*k)) & 32'hFF);
      b.d = {ref_comp(s[7:4]), ref_comp(s[3:0])};
      b.l = l && (k == 3);
      q.push_back(b);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive just after posedge, sample and score at negedge.
  task automatic cyc(input logic v, input logic [31:0] d, input logic l, input logic r);
    logic exp_rdy;
    i_tvalid = v; i_tdata = d; i_tlast = l; o_tready = r;
    @(negedge clk);
    obs_d = o_tdata; obs_l = o_tlast; obs_v = o_tvalid; obs_r = i_tready;
    exp_rdy = (q.size() == 0) || (q.size() == 1 && r);
    chk("o_tvalid", {31'b0, obs_v}, {31'b0, q.size() != 0});
    chk("i_tready", {31'b0, obs_r}, {31'b0, exp_rdy});
    if (q.size() != 0) begin
      chk("o_tdata", obs_d, q[0].d);
      chk("o_tlast", {31'b0, obs_l}, {31'b0, q[0].l});
      if (r) begin
        void'(q.pop_front());
        beats_rx++;
      end
    end
    if (v && exp_rdy) begin
      push_word(d, l);
      words_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] gold [4];
  logic [31:0] gold_rnd;
  int          cnt_rdy;
  int          guard;

  initial begin
`ifdef KEEP_ONE_IN_N_UNZIP_ROUND_EN
    gold[0] = 32'hCC00E400; gold[1] = 32'h1C00FC00;
    gold[2] = 32'h04000400; gold[3] = 32'hC4000C00;
    gold_rnd = 32'hCC00E400;
`else
    gold[0] = 32'hC800E000; gold[1] = 32'h1800F800;
    gold[2] = 32'h00000000; gold[3] = 32'hC0000800;
    gold_rnd = 32'hC800E000;
`endif
    words_acc = 0; beats_rx = 0;
    reset = 1'b1; i_tvalid = 1'b0; i_tdata = '0; i_tlast = 1'b0; o_tready = 1'b0;
    #1;
    chk("rst_o_tvalid", {31'b0, o_tvalid}, 32'd0);
    chk("rst_o_tlast", {31'b0, o_tlast}, 32'd0);
    chk("rst_o_tdata", o_tdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1 chk("rdy_after_rst", {31'b0, i_tready}, 32'd1);
    @(posedge clk); #1;

    // Known vector, tlast low then high.
    for (int t = 0; t < 2; t++) begin
      cyc(1'b1, 32'h9C3F0081, t[0], 1'b1);
      for (int k = 0; k < 4; k++) begin
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk($sformatf("vec_t%0d_b%0d", t, k), obs_d, gold[k]);
        chk($sformatf("vec_last_t%0d_b%0d", t, k), {31'b0, obs_l}, {31'b0, t == 1 && k == 3});
      end
    end

    cyc(1'b1, 32'h9C9C9C9C, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      chk($sformatf("rnd_b%0d", k), obs_d, gold_rnd);
    end

    // Back-to-back: one acceptance every 4th cycle, no output gaps.
    cnt_rdy = 0;
    cyc(1'b1, $urandom, 1'($urandom), 1'b1);
    for (int c = 0; c < 20; c++) begin
      cyc(1'b1, $urandom, 1'($urandom), 1'b1);
      if (obs_r) cnt_rdy++;
      chk("b2b_valid", {31'b0, obs_v}, 32'd1);
    end
    chk("b2b_ready_cnt", cnt_rdy, 32'd5);
    for (int c = 0; c < 4; c++) cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("b2b_drained", q.size(), 32'd0);

    // Random stalls over 100 words.
    words_acc = 0; beats_rx = 0; guard = 0;
    while (words_acc < 100 && guard < 5000) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom), 1'($urandom_range(0, 2) != 0));
      guard++;
    end
    chk("rand_words_timeout", {31'b0, words_acc == 100}, 32'd1);
    guard = 0;
    while (q.size() != 0 && guard < 1000) begin
      cyc(1'b0, $urandom, 1'b0, 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("rand_beats", beats_rx, 32'd400);

    // Reset after beat 1 of a word.
    cyc(1'b1, 32'h12345678, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, o_tvalid}, 32'd0);
    chk("mid_rst_tdata", o_tdata, 32'h0);
    chk("mid_rst_tlast", {31'b0, o_tlast}, 32'd0);
    q.delete();
    @(negedge clk); reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, i_tready}, 32'd1);
    chk("post_rst_valid", {31'b0, o_tvalid}, 32'd0);
    @(posedge clk); #1;
    cyc(1'b1, 32'h9C3F0081, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("post_rst_first", obs_d, gold[0]);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("post_rst_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
